// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: address/data words, funct3 codes,
// FSM states and the legality/alignment helpers.
package load_store_unit_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic m;
    case (f3)
      F3_H, F3_HU: m = lo[0];
      F3_W:        m = (lo != 2'b00);
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store replication and strobes, load extraction
// with sign/zero extension.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  input  data_t      wdata_i,
  input  data_t      rdata_i,
  output data_t      wdata_o,
  output logic [3:0] strb_o,
  output data_t      rdata_o
);

  data_t rsh;

  always_comb begin
    wdata_o = wdata_i;
    strb_o  = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_o = {4{wdata_i[7:0]}};
        strb_o  = 4'b0001 << addr_lo_i;
      end
      2'b01: begin
        wdata_o = {2{wdata_i[15:0]}};
        strb_o  = 4'b0011 << {addr_lo_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign rsh = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{rsh[7]}}, rsh[7:0]};
      F3_H:    rdata_o = {{16{rsh[15]}}, rsh[15:0]};
      F3_W:    rdata_o = rsh;
      F3_BU:   rdata_o = {24'b0, rsh[7:0]};
      F3_HU:   rdata_o = {16'b0, rsh[15:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> DONE, with
// misaligned/illegal requests short-circuiting straight to DONE.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_funct3,
  input  addr_t      req_addr,
  input  data_t      req_wdata,
  output logic       resp_valid,
  output data_t      resp_rdata,
  output logic       resp_error,
  output addr_t      mem_address,
  output data_t      mem_write_data,
  output logic [3:0] mem_write_enable,
  input  data_t      mem_read_data
);

  lsu_state_e state_q, state_d;
  logic       we_q, we_d;
  logic [2:0] f3_q, f3_d;
  addr_t      addr_q, addr_d;
  data_t      wdata_q, wdata_d;
  logic       err_q, err_d;

  logic [3:0] strb;
  data_t      ld_data;
  logic       bad;

  assign bad = !f3_legal(req_we, req_funct3)
             || misaligned(req_funct3, req_addr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = bad;
          state_d = bad ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  lsu_lane_align u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_read_data),
    .wdata_o   (mem_write_data),
    .strb_o    (strb),
    .rdata_o   (ld_data)
  );

  // Address stays on the latched word so MMIO read paths hold through DONE
  assign mem_address = {addr_q[31:2], 2'b00};

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_error = (state_q == ST_DONE) && err_q;

  assign mem_write_enable =
    (state_q == ST_ACCESS && we_q && !err_q) ? strb : 4'b0000;

  assign resp_rdata =
    (state_q == ST_DONE && !we_q && !err_q) ? ld_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a synchronous word RAM
// and a LEDR register at 0x10000000.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_enable;
  logic [31:0] mem_read_data;

  load_store_unit dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:255];
  logic [31:0] ledr;
  logic [31:0] rd_q;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_write_enable[b]) begin
        if (mem_address == 32'h1000_0000)
          ledr[b*8 +: 8] <= mem_write_data[b*8 +: 8];
        else
          ram[mem_address[9:2]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
      end
    end
    rd_q <= (mem_address == 32'h1000_0000) ? ledr : ram[mem_address[9:2]];
  end
  assign mem_read_data = rd_q;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } sb_t;
  sb_t sbq[$];

  logic [7:0] shadow [int unsigned];

  function automatic logic [7:0] sb_byte(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return 8'h00;
  endfunction

  function automatic logic m_bad(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a);
    logic legal;
    if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2)
                 || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = sb_byte(a);
    h = {sb_byte(a + 1), sb_byte(a)};
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {{16{h[15]}}, h};
      3'd2: return {sb_byte(a + 3), sb_byte(a + 2), h};
      3'd4: return {24'h0, b};
      3'd5: return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3,
                                        input logic [31:0] a);
    case (f3)
      3'd0: return 4'b0001 << a[1:0];
      3'd1: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                       input logic [31:0] d);
    case (f3)
      3'd0: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'd1: return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
    shadow[a] = d[7:0];
    if (f3 != 3'd0) shadow[a + 1] = d[15:8];
    if (f3 == 3'd2) begin
      shadow[a + 2] = d[23:16];
      shadow[a + 3] = d[31:24];
    end
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sbq.size() == 0) begin
        check("sb_extra_resp", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("sb_rdata", resp_rdata, e.rdata);
        check("sb_error", {31'b0, resp_error}, {31'b0, e.err});
      end
    end
  end

  logic [3:0]  last_strb;
  logic [31:0] last_wd;
  int          last_nstrb;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    sb_t  e;
    logic bad;
    int   lat;
    bad     = m_bad(we, f3, a);
    e.err   = bad;
    e.rdata = (bad || we) ? 32'h0 : m_load(f3, a);
    @(negedge clk);
    check("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    sbq.push_back(e);
    @(negedge clk);
    req_valid  = 1'b0;
    lat        = 1;
    last_strb  = 4'b0;
    last_wd    = 32'h0;
    last_nstrb = 0;
    while (!resp_valid && lat < 8) begin
      if (mem_write_enable != 4'b0) begin
        last_strb = mem_write_enable;
        last_wd   = mem_write_data;
        last_nstrb++;
      end
      @(negedge clk);
      lat++;
    end
    last_rdata = resp_rdata;
    last_err   = resp_error;
    check("latency", 32'(lat), bad ? 32'd1 : 32'd2);
    check("done_addr", mem_address, {a[31:2], 2'b00});
    check("strobe", {28'b0, last_strb},
          (we && !bad) ? {28'b0, m_strb(f3, a)} : 32'd0);
    if (we && !bad) begin
      check("wdata", last_wd, m_wd(f3, wd));
      m_store(f3, a, wd);
    end
  endtask

  initial begin
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    ledr       = 32'h0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    reset = 1'b1;
    #12;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_error", {31'b0, resp_error}, 32'd0);
    check("rst_strb", {28'b0, mem_write_enable}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_req(1'b1, 3'd2, 32'h8, 32'hDEADBEEF);
    check("sw_strb", {28'b0, last_strb}, 32'hF);
    check("sw_nstrb", 32'(last_nstrb), 32'd1);
    do_req(1'b0, 3'd2, 32'h8, 32'h0);
    check("lw_rdata", last_rdata, 32'hDEADBEEF);
    check("lw_err", {31'b0, last_err}, 32'd0);

    do_req(1'b1, 3'd0, 32'hB, 32'h00000080);
    check("sb_strb", {28'b0, last_strb}, 32'h8);
    check("sb_wd", last_wd, 32'h80808080);
    do_req(1'b0, 3'd0, 32'hB, 32'h0);
    check("lb_rdata", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'hB, 32'h0);
    check("lbu_rdata", last_rdata, 32'h00000080);

    do_req(1'b1, 3'd1, 32'h6, 32'h00008001);
    check("sh_strb", {28'b0, last_strb}, 32'hC);
    do_req(1'b0, 3'd1, 32'h6, 32'h0);
    check("lh_rdata", last_rdata, 32'hFFFF8001);

    do_req(1'b0, 3'd2, 32'h5, 32'h0);
    check("lw_mis_err", {31'b0, last_err}, 32'd1);
    check("lw_mis_rdata", last_rdata, 32'd0);
    do_req(1'b1, 3'd1, 32'h3, 32'h1234);
    check("sh_mis_err", {31'b0, last_err}, 32'd1);
    check("sh_mis_strb", {28'b0, last_strb}, 32'd0);

    do_req(1'b1, 3'd2, 32'h10000000, 32'h3FF);
    check("ledr", ledr, 32'h3FF);
    do_req(1'b0, 3'd2, 32'h10000000, 32'h0);
    check("ledr_rd", last_rdata, 32'h000003FF);

    do_req(1'b1, 3'd2, 32'h4, 32'hCAFEF00D);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h4;
    req_wdata  = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_pre_strb", {28'b0, mem_write_enable}, 32'hF);
    #1 reset = 1'b1;
    #1;
    check("abort_strb", {28'b0, mem_write_enable}, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_addr", mem_address, 32'd0);
    check("abort_wdata", mem_write_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    do_req(1'b0, 3'd2, 32'h4, 32'h0);
    check("abort_keep", last_rdata, 32'hCAFEF00D);

    for (int i = 0; i < 24; i++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'h40 + 32'($urandom_range(0, 15)), $urandom);
    end

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
